rx_cmd_ctrl: RTL
================

Name: rx_cmd_ctrl

Overview:
- Command sequencer between the UART receiver and the system's register file, ALU and TX FIFO.
- Consumes byte strobes from the UART RX, already synchronised into the reference (REF_CLK) domain.
- Parses fixed command frames, issues single-cycle register-file and ALU strobes, and pushes response bytes into the TX FIFO.

Parameters:
- DATA_W, 8: byte width of RX data, register-file data and FIFO data.
- ADDR_W, 4: register-file address width.
- FUN_W, 4: ALU function code width.
- TIMEOUT, 255: maximum cycles to wait for RF_RD_VLD or ALU_OUT_VLD before aborting.

Ports:
- CLK in 1: reference clock; all logic on the rising edge.
- RST in 1: reset; synchronous, active-low.
- RX_P_DATA in DATA_W: received byte.
- RX_D_VLD in 1: one-cycle strobe; RX_P_DATA is valid in that cycle.
- RX_PAR_ERR in 1: parity error for the strobed byte.
- RX_STP_ERR in 1: stop-bit error for the strobed byte.
- RF_WR_EN out 1: register-file write strobe.
- RF_RD_EN out 1: register-file read strobe.
- RF_ADDR out ADDR_W: register-file address.
- RF_WR_DATA out DATA_W: register-file write data.
- RF_RD_DATA in DATA_W: register-file read data.
- RF_RD_VLD in 1: read data valid.
- ALU_EN out 1: ALU start strobe.
- ALU_FUN out FUN_W: ALU function code.
- CLK_GATE_EN out 1: enables the gated ALU clock.
- ALU_OUT in 2*DATA_W: ALU result.
- ALU_OUT_VLD in 1: ALU result valid.
- TX_WR_DATA out DATA_W: FIFO write data.
- TX_WR_INC out 1: FIFO push strobe.
- TX_FULL in 1: FIFO full.
- CMD_ERR out 1: one-cycle pulse when a command is aborted.

Behaviour:
- Reset (RST low at a CLK edge): all outputs 0 and state IDLE. Reset mid-command discards the command; no strobe is issued afterwards.
- Byte acceptance: a byte is accepted only in a cycle with RX_D_VLD=1.
- Errored byte: if RX_PAR_ERR or RX_STP_ERR is also 1, the byte is not used. Outside IDLE: pulse CMD_ERR the next cycle and go to IDLE. In IDLE: drop silently.
- Command bytes, decoded in IDLE:
  - 0xAA: write, frame AA addr data.
  - 0xBB: read, frame BB addr.
  - 0xCC: ALU with operands, frame CC A B fun.
  - 0xDD: ALU without operands, frame DD fun.
  - Any other value: ignored, stay in IDLE.
- Address and function fields: addr uses the low ADDR_W bits of the byte; fun uses the low FUN_W bits.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_LO, TX_HI, TX_RD.
- Write path:
  - WR_ADDR latches addr, then WR_DATA.
  - On the data byte, the next cycle drives RF_WR_EN=1 for exactly one cycle with RF_ADDR and RF_WR_DATA, then IDLE.
- Read path:
  - On the addr byte in RD_ADDR, the next cycle drives RF_RD_EN=1 for one cycle with RF_ADDR, then RD_WAIT.
  - On RF_RD_VLD, latch RF_RD_DATA and go to TX_RD.
- Operand path:
  - OPA byte: RF write to address 0 (same one-cycle strobe as the write path).
  - OPB byte: RF write to address 1.
  - Both writes complete before the function byte is accepted; a byte arriving during a write strobe cycle is still accepted, since strobes overlap reception.
- FUN state:
  - On the function byte, the next cycle pulses ALU_EN for one cycle with ALU_FUN held, then ALU_WAIT.
  - CLK_GATE_EN rises in the ALU_EN cycle and falls the cycle after ALU_OUT_VLD is seen.
  - On ALU_OUT_VLD, latch ALU_OUT and go to TX_LO.
- Timeout: in RD_WAIT or ALU_WAIT, a counter runs from 0. Reaching TIMEOUT without the valid input: pulse CMD_ERR, drop CLK_GATE_EN, go to IDLE.
- TX push:
  - TX_LO pushes low byte, TX_HI pushes high byte, TX_RD pushes the read byte.
  - Each push: TX_WR_INC=1 for one cycle with TX_WR_DATA, only in a cycle with TX_FULL=0. While TX_FULL=1 the push is held and the state is unchanged.
  - After TX_HI or TX_RD: IDLE.
- Strobe discipline: all strobes are single-cycle and never assert simultaneously. RX_D_VLD arriving in wait or push states is ignored, with no error.
- Latency: RF write = 1 cycle after the final byte strobe. RF read strobe = 1 cycle after the addr strobe. Response push = 1 cycle after the valid input when TX_FULL=0.

Decomposition:
- Shared package rx_cmd_pkg holds:
  - Command opcode constants CMD_WR=8'hAA, CMD_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD.
  - The FSM state enumeration.
  - Operand register addresses OPA_ADDR=0 and OPB_ADDR=1.
- One sub-module: rx_cmd_timeout, a loadable wait counter with clear, enable and expire output, sized by TIMEOUT.

Test Plan:
- Write: strobe AA, 05, 3C -> one RF_WR_EN pulse with RF_ADDR=5, RF_WR_DATA=0x3C; no TX push.
- Read: strobe BB, 05; RF returns 0x3C with RF_RD_VLD 3 cycles later -> one RF_RD_EN pulse with RF_ADDR=5; then one TX_WR_INC with 0x3C.
- ALU with operands: strobe CC, 0x12, 0x34, fun=0; ALU_OUT=0x0046 valid -> RF writes addr0=0x12 and addr1=0x34; ALU_EN with ALU_FUN=0; TX pushes 0x46 then 0x00; CLK_GATE_EN high only from ALU_EN through ALU_OUT_VLD+1.
- Backpressure: DD, fun=2; ALU_OUT=0xABCD; TX_FULL high for 10 cycles -> no push while full; then 0xCD and 0xAB on consecutive free cycles.
- Errors:
  - Strobe AA, then 05 with RX_PAR_ERR=1 -> CMD_ERR pulse, IDLE, no RF_WR_EN.
  - Read with no RF_RD_VLD -> CMD_ERR after TIMEOUT cycles.
  - Unknown byte 0x55 -> ignored.
- Reset: drop RST during ALU_WAIT -> all outputs 0 next edge; a following AA, 01, 07 completes normally.

Source files
------------

// File: rtl/rx_cmd_pkg.sv
// rtl/rx_cmd_pkg.sv - shared opcodes, operand addresses and FSM states for rx_cmd_ctrl
package rx_cmd_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OPA,
        OPB,
        FUN,
        ALU_WAIT,
        TX_LO,
        TX_HI,
        TX_RD
    } state_e;

endpackage

// File: rtl/rx_cmd_timeout.sv
// rtl/rx_cmd_timeout.sv - loadable wait counter that flags expiry after TIMEOUT enabled cycles
module rx_cmd_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic                             clr_i,
    input  logic                             en_i,
    input  logic                             load_i,
    input  logic [$clog2(TIMEOUT+1)-1:0]     load_val_i,
    output logic                             expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturates at LIMIT so a stalled wait never wraps back to a fresh count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/rx_cmd_ctrl.sv
// rtl/rx_cmd_ctrl.sv - UART command frame sequencer driving register file, ALU and TX FIFO
module rx_cmd_ctrl
    import rx_cmd_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int FUN_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [DATA_W-1:0]   RX_P_DATA,
    input  logic                RX_D_VLD,
    input  logic                RX_PAR_ERR,
    input  logic                RX_STP_ERR,
    output logic                RF_WR_EN,
    output logic                RF_RD_EN,
    output logic [ADDR_W-1:0]   RF_ADDR,
    output logic [DATA_W-1:0]   RF_WR_DATA,
    input  logic [DATA_W-1:0]   RF_RD_DATA,
    input  logic                RF_RD_VLD,
    output logic                ALU_EN,
    output logic [FUN_W-1:0]    ALU_FUN,
    output logic                CLK_GATE_EN,
    input  logic [2*DATA_W-1:0] ALU_OUT,
    input  logic                ALU_OUT_VLD,
    output logic [DATA_W-1:0]   TX_WR_DATA,
    output logic                TX_WR_INC,
    input  logic                TX_FULL,
    output logic                CMD_ERR
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e              state_q;
    logic                rf_wr_en_q;
    logic                rf_rd_en_q;
    logic                alu_en_q;
    logic                clk_gate_q;
    logic                cmd_err_q;
    logic [ADDR_W-1:0]   rf_addr_q;
    logic [DATA_W-1:0]   rf_wr_data_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic [FUN_W-1:0]    alu_fun_q;
    logic [2*DATA_W-1:0] alu_res_q;

    logic byte_ok;
    logic byte_bad;
    logic consuming;
    logic waiting;
    logic pushing;
    logic expired;

    assign byte_ok   = RX_D_VLD && !(RX_PAR_ERR || RX_STP_ERR);
    assign byte_bad  = RX_D_VLD &&  (RX_PAR_ERR || RX_STP_ERR);
    assign consuming = (state_q == WR_ADDR) || (state_q == WR_DATA) || (state_q == RD_ADDR) ||
                       (state_q == OPA)     || (state_q == OPB)     || (state_q == FUN);
    assign waiting   = (state_q == RD_WAIT) || (state_q == ALU_WAIT);
    assign pushing   = (state_q == TX_LO) || (state_q == TX_HI) || (state_q == TX_RD);

    rx_cmd_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk_i      (CLK),
        .rstn_i     (RST),
        .clr_i      (!waiting),
        .en_i       (waiting),
        .load_i     (1'b0),
        .load_val_i ({CNT_W{1'b0}}),
        .expire_o   (expired)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= IDLE;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            alu_en_q     <= 1'b0;
            clk_gate_q   <= 1'b0;
            cmd_err_q    <= 1'b0;
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
            rd_data_q    <= '0;
            alu_fun_q    <= '0;
            alu_res_q    <= '0;
        end else begin
            rf_wr_en_q <= 1'b0;
            rf_rd_en_q <= 1'b0;
            alu_en_q   <= 1'b0;
            cmd_err_q  <= 1'b0;

            if (byte_bad && consuming) begin
                cmd_err_q <= 1'b1;
                state_q   <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (byte_ok) begin
                            case (RX_P_DATA)
                                CMD_WR:      state_q <= WR_ADDR;
                                CMD_RD:      state_q <= RD_ADDR;
                                CMD_ALU_OP:  state_q <= OPA;
                                CMD_ALU_NOP: state_q <= FUN;
                                default:     state_q <= IDLE;
                            endcase
                        end
                    end
                    WR_ADDR: begin
                        if (byte_ok) begin
                            rf_addr_q <= RX_P_DATA[ADDR_W-1:0];
                            state_q   <= WR_DATA;
                        end
                    end
                    WR_DATA: begin
                        if (byte_ok) begin
                            rf_wr_data_q <= RX_P_DATA;
                            rf_wr_en_q   <= 1'b1;
                            state_q      <= IDLE;
                        end
                    end
                    RD_ADDR: begin
                        if (byte_ok) begin
                            rf_addr_q  <= RX_P_DATA[ADDR_W-1:0];
                            rf_rd_en_q <= 1'b1;
                            state_q    <= RD_WAIT;
                        end
                    end
                    RD_WAIT: begin
                        if (RF_RD_VLD) begin
                            rd_data_q <= RF_RD_DATA;
                            state_q   <= TX_RD;
                        end else if (expired) begin
                            cmd_err_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end
                    // Operand bytes may arrive while the previous write strobe is still out.
                    OPA: begin
                        if (byte_ok) begin
                            rf_addr_q    <= ADDR_W'(OPA_ADDR);
                            rf_wr_data_q <= RX_P_DATA;
                            rf_wr_en_q   <= 1'b1;
                            state_q      <= OPB;
                        end
                    end
                    OPB: begin
                        if (byte_ok) begin
                            rf_addr_q    <= ADDR_W'(OPB_ADDR);
                            rf_wr_data_q <= RX_P_DATA;
                            rf_wr_en_q   <= 1'b1;
                            state_q      <= FUN;
                        end
                    end
                    FUN: begin
                        if (byte_ok) begin
                            alu_fun_q  <= RX_P_DATA[FUN_W-1:0];
                            alu_en_q   <= 1'b1;
                            clk_gate_q <= 1'b1;
                            state_q    <= ALU_WAIT;
                        end
                    end
                    ALU_WAIT: begin
                        if (ALU_OUT_VLD) begin
                            alu_res_q  <= ALU_OUT;
                            clk_gate_q <= 1'b0;
                            state_q    <= TX_LO;
                        end else if (expired) begin
                            cmd_err_q  <= 1'b1;
                            clk_gate_q <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                    TX_LO: if (!TX_FULL) state_q <= TX_HI;
                    TX_HI: if (!TX_FULL) state_q <= IDLE;
                    TX_RD: if (!TX_FULL) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Push is qualified by the live TX_FULL so a byte never lands in a full FIFO.
    always_comb begin
        TX_WR_DATA = '0;
        case (state_q)
            TX_LO:   TX_WR_DATA = alu_res_q[DATA_W-1:0];
            TX_HI:   TX_WR_DATA = alu_res_q[2*DATA_W-1:DATA_W];
            TX_RD:   TX_WR_DATA = rd_data_q;
            default: TX_WR_DATA = '0;
        endcase
    end

    assign TX_WR_INC   = pushing && !TX_FULL;
    assign RF_WR_EN    = rf_wr_en_q;
    assign RF_RD_EN    = rf_rd_en_q;
    assign RF_ADDR     = rf_addr_q;
    assign RF_WR_DATA  = rf_wr_data_q;
    assign ALU_EN      = alu_en_q;
    assign ALU_FUN     = alu_fun_q;
    assign CLK_GATE_EN = clk_gate_q;
    assign CMD_ERR     = cmd_err_q;

endmodule
